// File: rtl/wb_sram32_pkg.sv
// Shared state encoding, idle pin levels and helpers for the wb_sram32 SRAM bridge.
package wb_sram32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_ACK   = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5
  } state_e;

  localparam logic [3:0] SRAM_IDLE_BE_N = 4'b1111;
  localparam logic [1:0] SRAM_IDLE_CE_N = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_sram32_rdbuf.sv
// One-entry read buffer for wb_sram32: a word address, its data and a valid flag.
// Only built when WB_SRAM32_RDBUF_EN is defined.
`ifdef WB_SRAM32_RDBUF_EN
module wb_sram32_rdbuf #(
  parameter int adr_width = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [adr_width-1:0] lookup_adr,
  input  logic                 inval,
  input  logic                 fill,
  input  logic [adr_width-1:0] fill_adr,
  input  logic [31:0]          fill_dat,
  output logic                 hit,
  output logic [31:0]          hit_dat
);

  logic                 valid_q, valid_d;
  logic [adr_width-1:0] adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;

  always_comb begin
    valid_d = valid_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    if (inval) begin
      valid_d = 1'b0;
    end else if (fill) begin
      valid_d = 1'b1;
      adr_d   = fill_adr;
      dat_d   = fill_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= 1'b0;
    else          valid_q <= valid_d;
  end

  // NOTE: the stored address/data need no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    adr_q <= adr_d;
    dat_q <= dat_d;
  end

  assign hit     = valid_q && (adr_q == lookup_adr);
  assign hit_dat = dat_q;

endmodule
`endif

// File: rtl/wb_sram32.sv
// Wishbone classic-cycle slave driving two 16-bit async SRAMs as one 32-bit word.
// Define WB_SRAM32_RDBUF_EN to add a one-entry read buffer.
module wb_sram32
  import wb_sram32_pkg::*;
#(
  parameter int adr_width = 18,
  parameter int rd_wait   = 2,
  parameter int wr_pulse  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] sram_adr,
  inout  logic [31:0]          sram_dat,
  output logic [3:0]           sram_be_n,
  output logic [1:0]           sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  localparam int CNT_W = $clog2(max_int(rd_wait, wr_pulse) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(rd_wait - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(wr_pulse - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 abort_q, abort_d;
  logic                 ack_q, ack_d;
  logic [31:0]          rdat_q, rdat_d;
  logic [31:0]          wdat_q, wdat_d;
  logic                 drive_q, drive_d;
  logic [adr_width-1:0] adr_q, adr_d;
  logic [3:0]           be_n_q, be_n_d;
  logic [1:0]           ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;

  logic                 req;
  logic                 rdbuf_hit;
  logic [31:0]          rdbuf_dat;
  logic                 unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i >> (adr_width + 2)};

`ifdef WB_SRAM32_RDBUF_EN
  wb_sram32_rdbuf #(.adr_width(adr_width)) u_rdbuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_adr (wb_adr_i[adr_width+1:2]),
    .inval      (state_q == ST_IDLE && req && wb_we_i),
    .fill       (state_q == ST_RD && cnt_q == '0 && be_n_q == 4'b0000),
    .fill_adr   (adr_q),
    .fill_dat   (sram_dat),
    .hit        (rdbuf_hit),
    .hit_dat    (rdbuf_dat)
  );
`else
  assign rdbuf_hit = 1'b0;
  assign rdbuf_dat = '0;
`endif

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    wdat_d  = wdat_q;
    drive_d = drive_q;
    adr_d   = adr_q;
    be_n_d  = be_n_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          adr_d  = wb_adr_i[adr_width+1:2];
          be_n_d = ~wb_sel_i;
          if (wb_we_i) begin
            ce_n_d  = 2'b00;
            wdat_d  = wb_dat_i;
            drive_d = 1'b1;
            state_d = ST_WR_SETUP;
          end else if (rdbuf_hit) begin
            // Buffered read: the SRAM pins stay idle.
            be_n_d  = SRAM_IDLE_BE_N;
            rdat_d  = rdbuf_dat;
            ack_d   = 1'b1;
            state_d = ST_RD_ACK;
          end else begin
            ce_n_d  = 2'b00;
            oe_n_d  = 1'b0;
            cnt_d   = RD_LOAD;
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        abort_d = abort_q | ~wb_cyc_i;
        if (cnt_q == '0) begin
          rdat_d  = sram_dat;
          oe_n_d  = 1'b1;
          ce_n_d  = SRAM_IDLE_CE_N;
          be_n_d  = SRAM_IDLE_BE_N;
          ack_d   = wb_cyc_i & ~abort_q;
          state_d = ST_RD_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RD_ACK: state_d = ST_IDLE;

      ST_WR_SETUP: begin
        abort_d = abort_q | ~wb_cyc_i;
        we_n_d  = 1'b0;
        cnt_d   = WR_LOAD;
        state_d = ST_WR_PULSE;
      end

      ST_WR_PULSE: begin
        abort_d = abort_q | ~wb_cyc_i;
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          ack_d   = wb_cyc_i & ~abort_q;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR_HOLD: begin
        drive_d = 1'b0;
        ce_n_d  = SRAM_IDLE_CE_N;
        be_n_d  = SRAM_IDLE_BE_N;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      wdat_q  <= '0;
      drive_q <= 1'b0;
      adr_q   <= '0;
      be_n_q  <= SRAM_IDLE_BE_N;
      ce_n_q  <= SRAM_IDLE_CE_N;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      wdat_q  <= wdat_d;
      drive_q <= drive_d;
      adr_q   <= adr_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign sram_dat  = drive_q ? wdat_q : {32{1'bz}};
  assign wb_dat_o  = rdat_q;
  assign wb_ack_o  = ack_q;
  assign sram_adr  = adr_q;
  assign sram_be_n = be_n_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_wb_sram32.sv
// Directed and random bench for wb_sram32 against a behavioural async SRAM and a word scoreboard.
// Define WB_SRAM32_RDBUF_EN to also exercise the read buffer.
module tb_wb_sram32;

  localparam int ADR_W    = 18;
  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 2;
  localparam int RD_LAT   = RD_WAIT + 1;
  localparam int WR_LAT   = WR_PULSE + 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]      wb_adr_i, wb_dat_i;
  logic [3:0]       wb_sel_i;
  logic [31:0]      wb_dat_o;
  logic             wb_ack_o;
  logic [ADR_W-1:0] sram_adr;
  wire  [31:0]      sram_dat;
  logic [3:0]       sram_be_n;
  logic [1:0]       sram_ce_n;
  logic             sram_oe_n, sram_we_n;

  logic [31:0] sram_mem [0:255];
  logic [31:0] ref_mem  [0:255];

  int n_checks = 0;
  int n_errors = 0;
  int we_low_cnt = 0;
  int oe_low_cnt = 0;
  logic [3:0]       pulse_be_n = 4'h0;
  logic [ADR_W-1:0] pulse_adr  = '0;
  logic             wr_active  = 1'b0;
  logic             prev_ack   = 1'b0;

  always #5 clk = ~clk;

  wb_sram32 #(.adr_width(ADR_W), .rd_wait(RD_WAIT), .wr_pulse(WR_PULSE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .sram_adr  (sram_adr),
    .sram_dat  (sram_dat),
    .sram_be_n (sram_be_n),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  // Undriven bus floats high, so a released bus reads as all ones.
  for (genvar i = 0; i < 32; i++) begin : g_pull
    pullup (sram_dat[i]);
  end

  // Async SRAM model: lane l belongs to chip l/2.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign sram_dat[8*l+7 -: 8] =
      (!sram_ce_n[l/2] && !sram_oe_n && sram_we_n && !sram_be_n[l]) ?
      sram_mem[sram_adr[7:0]][8*l+7 -: 8] : 8'hzz;
  end

  always @(posedge sram_we_n) begin
    for (int l = 0; l < 4; l++)
      if (!sram_ce_n[l/2] && !sram_be_n[l])
        sram_mem[sram_adr[7:0]][8*l +: 8] = sram_dat[8*l +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!sram_we_n) begin
      we_low_cnt++;
      pulse_be_n = sram_be_n;
      pulse_adr  = sram_adr;
    end
    if (!sram_oe_n) oe_low_cnt++;
    if (wr_active) check("oe_high_in_write", 32'(sram_oe_n), 32'd1);
    if (prev_ack) check("ack_single_cycle", 32'(wb_ack_o), 32'd0);
    prev_ack = wb_ack_o;
  end

  // Call at a falling edge; returns one falling edge after the ack cycle, with the bus idle.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_sel_i = sel;
    wb_dat_i = wdat;
    lat  = 0;
    rdat = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        lat  = n;
        rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] data, output int lat);
    logic [31:0] unused_rd;
    we_low_cnt = 0;
    wr_active  = 1'b1;
    xfer(1'b1, adr, sel, data, unused_rd, lat);
    wr_active  = 1'b0;
    for (int l = 0; l < 4; l++)
      if (sel[l]) ref_mem[adr[9:2]][8*l +: 8] = data[8*l +: 8];
  endtask

  task automatic do_read(input logic [31:0] adr, output logic [31:0] rdat, output int lat);
    oe_low_cnt = 0;
    xfer(1'b0, adr, 4'hF, 32'h0, rdat, lat);
  endtask

  initial begin
    logic [31:0] rdat;
    logic [31:0] a;
    logic [3:0]  sel;
    logic [31:0] d;
    logic        ack_seen;
    int          lat;

    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    reset_n  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_sel_i = '0;
    wb_dat_i = '0;
    repeat (3) @(negedge clk);

    check("rst_ack",   32'(wb_ack_o),  32'd0);
    check("rst_dat_o", wb_dat_o,        32'h0);
    check("rst_adr",   32'(sram_adr),  32'd0);
    check("rst_be_n",  32'(sram_be_n), 32'hF);
    check("rst_ce_n",  32'(sram_ce_n), 32'h3);
    check("rst_oe_n",  32'(sram_oe_n), 32'd1);
    check("rst_we_n",  32'(sram_we_n), 32'd1);
    check("rst_bus_z", sram_dat,        32'hFFFF_FFFF);
    reset_n = 1'b1;
    @(negedge clk);

    // Full-word write then read back.
    do_write(32'h10, 4'hF, 32'hDEAD_BEEF, lat);
    check("wr_lat",      32'(lat),        32'(WR_LAT));
    check("wr_pulse",    32'(we_low_cnt), 32'd2);
    check("wr_adr",      32'(pulse_adr),  32'd4);
    check("wr_be_n",     32'(pulse_be_n), 32'h0);
    do_read(32'h10, rdat, lat);
    check("rd_lat",      32'(lat),        32'(RD_LAT));
    check("rd_data",     rdat,            32'hDEAD_BEEF);
    check("rd_oe_len",   32'(oe_low_cnt), 32'd2);

    // Single byte lane.
    do_write(32'h10, 4'b0001, 32'h0000_00AA, lat);
    check("byte_lat",    32'(lat),        32'(WR_LAT));
    check("byte_be_n",   32'(pulse_be_n), 32'hE);
    do_read(32'h10, rdat, lat);
    check("byte_data",   rdat,            32'hDEAD_BEAA);

    // Empty byte mask still runs the whole write and is acked.
    do_write(32'h10, 4'b0000, 32'hFFFF_FFFF, lat);
    check("sel0_lat",    32'(lat),        32'(WR_LAT));
    check("sel0_pulse",  32'(we_low_cnt), 32'd2);
    check("sel0_be_n",   32'(pulse_be_n), 32'hF);
    do_read(32'h8010_0012, rdat, lat);
    check("alias_data",  rdat,            32'hDEAD_BEAA);

    // Abort a read in its first wait cycle.
    do_write(32'h44, 4'hF, 32'h5A5A_A5A5, lat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = 32'h40;
    wb_sel_i = 4'hF;
    @(negedge clk);
    check("abort_oe_low", 32'(sram_oe_n), 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wb_ack_o) ack_seen = 1'b1;
    end
    check("abort_no_ack", 32'(ack_seen),  32'd0);
    check("abort_oe_n",   32'(sram_oe_n), 32'd1);
    check("abort_ce_n",   32'(sram_ce_n), 32'h3);
    do_read(32'h44, rdat, lat);
    check("post_abort_lat",  32'(lat), 32'(RD_LAT));
    check("post_abort_data", rdat,     32'h5A5A_A5A5);

    // Asynchronous reset in the middle of the write pulse.
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 32'h400;
    wb_sel_i = 4'hF;
    wb_dat_i = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    check("pre_rst_bus",  sram_dat,       32'h1234_5678);
    #1 reset_n = 1'b0;
    #1;
    check("arst_we_n",  32'(sram_we_n), 32'd1);
    check("arst_bus_z", sram_dat,        32'hFFFF_FFFF);
    check("arst_ack",   32'(wb_ack_o),  32'd0);
    check("arst_dat_o", wb_dat_o,        32'h0);
    check("arst_adr",   32'(sram_adr),  32'd0);
    check("arst_be_n",  32'(sram_be_n), 32'hF);
    check("arst_ce_n",  32'(sram_ce_n), 32'h3);
    check("arst_oe_n",  32'(sram_oe_n), 32'd1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef WB_SRAM32_RDBUF_EN
    do_write(32'h20, 4'hF, 32'hCAFE_F00D, lat);
    do_read(32'h20, rdat, lat);
    check("buf_miss_lat",  32'(lat),        32'(RD_LAT));
    check("buf_miss_data", rdat,            32'hCAFE_F00D);
    do_read(32'h20, rdat, lat);
    check("buf_hit_lat",   32'(lat),        32'd1);
    check("buf_hit_data",  rdat,            32'hCAFE_F00D);
    check("buf_hit_oe",    32'(oe_low_cnt), 32'd0);
    do_write(32'h80, 4'hF, 32'h0000_0001, lat);
    do_read(32'h20, rdat, lat);
    check("buf_inval_lat", 32'(lat),        32'(RD_LAT));
    check("buf_inval_data", rdat,           32'hCAFE_F00D);
`endif

    // Random mix against the word scoreboard; upper and low address bits are noise.
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, 63)) << 2) |
          32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        sel = 4'($urandom_range(0, 15));
        d   = $urandom;
        do_write(a, sel, d, lat);
        check("rand_wr_lat", 32'(lat), 32'(WR_LAT));
      end else begin
        do_read(a, rdat, lat);
        check("rand_rd_data", rdat, ref_mem[a[9:2]]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_sram32.md
# wb_sram32

Wishbone slave bridge between the LM32 data/instruction bus arbiter and the board's external asynchronous SRAM (two 16-bit devices sharing address and control, forming a 32-bit word). It turns single classic-cycle Wishbone reads and writes into timed SRAM strobe sequences and drives the `sram_*` pins of `system` directly. Wait states are parameterised so simulation and the physical board can use different settings.

## Interface
- `adr_width`, 18: SRAM word address width.
- `rd_wait`, 2: cycles `sram_oe_n` is held low before data is sampled; ≥1.
- `wr_pulse`, 2: cycles `sram_we_n` is held low; ≥1.

- `clk` in 1: system clock.
- `reset_n` in 1: **one clock; reset is asynchronous and active-low**.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in 32: byte address.
- `wb_sel_i` in 4: byte lanes; bit 3 = `[31:24]`.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `sram_adr` out `adr_width`: word address.
- `sram_dat` inout 32: `[31:16]` goes to chip 1, `[15:0]` to chip 0.
- `sram_be_n` out 4: byte enables, active low.
- `sram_ce_n` out 2: chip enables, active low; both chips are always selected together.
- `sram_oe_n` out 1: output enable, active low.
- `sram_we_n` out 1: write enable, active low.

## Operation
- States: IDLE, RD, RD_ACK, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: when `wb_cyc_i & wb_stb_i` is sampled, register `sram_adr = wb_adr_i[adr_width+1:2]`, `sram_be_n = ~wb_sel_i`, and `sram_ce_n = 2'b00`.
  - `wb_we_i = 0`: go to RD and set `oe_n = 0`.
  - `wb_we_i = 1`: go to WR_SETUP and register `wb_dat_i`.
- RD: hold for `rd_wait` cycles, counted by a wait counter. On the last cycle, capture `sram_dat` into `wb_dat_o`, then go to RD_ACK.
- RD_ACK: `wb_ack_o = 1`, `oe_n = 1`, `ce_n = 11`, then go to IDLE.
- WR_SETUP: 1 cycle. Address, data and `ce_n` are driven; `we_n = 1`. Then go to WR_PULSE.
- WR_PULSE: `we_n = 0` for `wr_pulse` cycles. Then go to WR_HOLD.
- WR_HOLD: 1 cycle. `we_n = 1`, data is still driven, `wb_ack_o = 1`. Then go to IDLE.
- `sram_dat` is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is Z in all other states. `oe_n` is never low while `sram_dat` is driven.
- Address bits `[1:0]`, and bits above `adr_width+1`, are ignored. The upper address space therefore aliases onto the SRAM.
- Writes with `wb_sel_i = 0000` still run the full sequence with all byte enables high, and are acked.
- Abort: if `wb_cyc_i` drops in RD or WR_*, the SRAM sequence runs to completion but `wb_ack_o` stays 0, and the FSM returns to IDLE.

## Timing
- Reset values: state IDLE, `wb_ack_o = 0`, `wb_dat_o = 0`, `sram_adr = 0`, `sram_be_n = 1111`, `sram_ce_n = 11`, `sram_oe_n = 1`, `sram_we_n = 1`, `sram_dat` Z. Reset applies immediately and asynchronously. A reset in WR_PULSE raises `we_n` with no clock edge.
- Read latency: the request is sampled at edge 0, `oe_n` falls after edge 0, and `wb_ack_o` is high in cycle `rd_wait+1`.
  - Back-to-back read throughput is `rd_wait+2` cycles.
- Write latency: `wb_ack_o` is high in cycle `wr_pulse+2`.
  - Throughput is `wr_pulse+3` cycles.
- `wb_ack_o` is never high for two consecutive cycles. A new request is accepted only in IDLE, the cycle after an ack.
- All SRAM outputs are registered, so they are glitch-free.

## Configuration
- `WB_SRAM32_RDBUF_EN` defined: adds a one-entry read buffer holding a word address, its data, and a valid flag.
  - An IDLE read whose address matches a valid entry skips RD and acks in the next cycle (RD_ACK directly), with `oe_n` kept high.
  - Any write invalidates the entry.
  - Reset clears the valid flag.
- Not defined: every read performs a full SRAM cycle.

## Structure
- Shared package `wb_sram32_pkg` holds:
  - the state encoding constants;
  - the `SRAM_IDLE_BE_N = 4'b1111` and `SRAM_IDLE_CE_N = 2'b11` constants.
- The wait counter width is `$clog2(max(rd_wait, wr_pulse)+1)`.
- The tristate for `sram_dat` is a continuous assign inside the module. No sub-module is needed; with the read buffer enabled, the buffer sits in sub-module `wb_sram32_rdbuf`.

## Test plan
- Write then read (`rd_wait = 2`, `wr_pulse = 2`):
  - Write `0x0000_0010 ← 0xDEADBEEF`, `sel = 1111`: `sram_adr = 4`, `we_n` low for 2 cycles, ack in cycle 4.
  - Read `0x10`: returns `0xDEADBEEF`, ack in cycle 3.
- Byte lane: write `0x10 ← 0x000000AA`, `sel = 0001`, over `0xDEADBEEF` → read returns `0xDEADBEAA`; only `be_n[0] = 0` during the pulse.
- Bus contention check: assert that no cycle has `oe_n = 0` while the bridge drives `sram_dat`, across 1000 random reads and writes checked against a reference model.
- Abort: drop `wb_cyc_i` in the first RD cycle → no ack; the FSM is in IDLE 3 cycles later; the next read completes normally.
- Reset in WR_PULSE: assert `reset_n = 0` → `we_n = 1` and `sram_dat` Z in the same timestep; all outputs hold their reset values.
- `WB_SRAM32_RDBUF_EN`:
  - Two reads of `0x20` → the second acks 1 cycle after it is sampled, with `oe_n` staying high.
  - A write to any address, then a read of `0x20` → takes the full `rd_wait+1` latency.
